// File: rtl/cfg_mux_bank_pkg.sv
// Shared definitions for the run-time configurable mux bank: width helpers
// and the encoding of a commit outcome.
package cfg_mux_bank_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int sel_width(input int num_in);
    return clog2(num_in);
  endfunction

  function automatic int chain_width(input int num_in, input int num_out);
    return clog2(num_in) * num_out;
  endfunction

  // Result of the previous edge's commit request; drives the done/err pulses.
  typedef enum logic [1:0] {
    CMT_NONE = 2'd0,
    CMT_DONE = 2'd1,
    CMT_ERR  = 2'd2
  } commit_res_e;

endpackage

// File: rtl/cfg_mux_bank_if.sv
// Data and configuration-chain signals of one cfg_mux_bank.
// Commit handshake: cfg_commit is a single-cycle request with no back-pressure;
// exactly one of cfg_done/cfg_err pulses on the following cycle (none if rst).
interface cfg_mux_bank_if #(
    parameter int NUM_IN  = 4,
    parameter int NUM_OUT = 2
);
    logic [NUM_IN-1:0]  in;
    logic [NUM_OUT-1:0] out;
    logic               cfg_en;
    logic               cfg_din;
    logic               cfg_dout;
    logic               cfg_commit;
    logic               cfg_done;
    logic               cfg_err;

    modport master (
        output in, cfg_en, cfg_din, cfg_commit,
        input  out, cfg_dout, cfg_done, cfg_err
    );

    modport slave (
        input  in, cfg_en, cfg_din, cfg_commit,
        output out, cfg_dout, cfg_done, cfg_err
    );
endinterface

// File: rtl/cfg_mux_bank_sel.sv
// One output of the bank: NUM_IN:1 select with out-of-range fields decoding
// to 0, optionally followed by an output register.
module cfg_mux_sel #(
    parameter int NUM_IN  = 4,
    parameter int SEL_W   = 2,
    parameter int REG_OUT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_IN-1:0] in,
    input  logic [SEL_W-1:0]  sel,
    output logic              out
);
    logic d;
    logic q;

    // A select value with no matching input leaves d at 0.
    always_comb begin
        d = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (int'(sel) == i) d = in[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) q <= 1'b0;
        else     q <= d;
    end

    assign out = (REG_OUT != 0) ? q : d;
endmodule

// File: rtl/cfg_mux_bank.sv
// N-input, M-output mux bank whose selects come from an active register
// loaded from a serial shadow chain on an explicit commit.
module cfg_mux_bank
    import cfg_mux_bank_pkg::*;
#(
    parameter int NUM_IN      = 4,
    parameter int NUM_OUT     = 2,
    parameter int REG_OUT     = 1,
    parameter int DEFAULT_SEL = 0
) (
    input logic           clk,
    input logic           rst,
    cfg_mux_bank_if.slave bus
);
    localparam int SEL_W = sel_width(NUM_IN);
    localparam int CW    = chain_width(NUM_IN, NUM_OUT);
    localparam int CNT_W = clog2(CW + 1);

    localparam logic [SEL_W-1:0] DSEL     = SEL_W'(DEFAULT_SEL);
    localparam logic [CW-1:0]    RST_CFG  = {NUM_OUT{DSEL}};
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CW);

    logic [CW-1:0]      shadow;
    logic [CW-1:0]      shadow_nx;
    logic [CW-1:0]      active;
    logic [CNT_W-1:0]   cnt;
    commit_res_e        result;
    logic [NUM_OUT-1:0] out_w;

    // Written as shift-and-or so a one-bit chain needs no special case.
    assign shadow_nx = (shadow << 1) | CW'(bus.cfg_din);

    // Commit wins over shift; the counter saturates so over-long streams still
    // commit the most recent CW bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= RST_CFG;
            active <= RST_CFG;
            cnt    <= '0;
            result <= CMT_NONE;
        end else begin
            result <= CMT_NONE;
            if (bus.cfg_commit) begin
                cnt <= '0;
                if (cnt == CNT_FULL) begin
                    active <= shadow;
                    result <= CMT_DONE;
                end else begin
                    result <= CMT_ERR;
                end
            end else if (bus.cfg_en) begin
                shadow <= shadow_nx;
                if (cnt != CNT_FULL) cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign bus.cfg_dout = shadow[CW-1];
    assign bus.cfg_done = (result == CMT_DONE);
    assign bus.cfg_err  = (result == CMT_ERR);

    for (genvar j = 0; j < NUM_OUT; j++) begin : g_out
        cfg_mux_sel #(
            .NUM_IN  (NUM_IN),
            .SEL_W   (SEL_W),
            .REG_OUT (REG_OUT)
        ) u_sel (
            .clk (clk),
            .rst (rst),
            .in  (bus.in),
            .sel (active[j*SEL_W +: SEL_W]),
            .out (out_w[j])
        );
    end

    assign bus.out = out_w;
endmodule

// File: tb/tb_cfg_mux_bank.sv
// Bench for cfg_mux_bank: a registered 4-input bank and a combinational
// 3-input bank share one config stream and are checked against a bit-level model.
module tb_cfg_mux_bank;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic din = 1'b0;
  logic commit = 1'b0;
  logic [3:0] in4 = 4'b0000;

  int tests = 0;
  int fails = 0;

  // Model state, index 0 = bank A (4 inputs, registered), 1 = bank B (3 inputs, comb).
  int m_sh[2];
  int m_cnt[2];
  int m_act[2];
  logic [1:0] m_out[2];
  logic m_done[2];
  logic m_err[2];

  always #5 clk = ~clk;

  cfg_mux_bank_if #(.NUM_IN(4), .NUM_OUT(2)) a_if ();
  cfg_mux_bank_if #(.NUM_IN(3), .NUM_OUT(2)) b_if ();

  assign a_if.in = in4;
  assign a_if.cfg_en = en;
  assign a_if.cfg_din = din;
  assign a_if.cfg_commit = commit;
  assign b_if.in = in4[2:0];
  assign b_if.cfg_en = en;
  assign b_if.cfg_din = din;
  assign b_if.cfg_commit = commit;

  cfg_mux_bank #(.NUM_IN(4), .NUM_OUT(2), .REG_OUT(1), .DEFAULT_SEL(0)) dut_a (
    .clk(clk), .rst(rst), .bus(a_if)
  );
  cfg_mux_bank #(.NUM_IN(3), .NUM_OUT(2), .REG_OUT(0), .DEFAULT_SEL(0)) dut_b (
    .clk(clk), .rst(rst), .bus(b_if)
  );

  // Output j picks the 2-bit field (act / 4^j) mod 4; absent inputs give 0.
  function automatic logic [1:0] route(input int act, input logic [3:0] v, input int nin);
    logic [1:0] r;
    int s;
    for (int j = 0; j < 2; j++) begin
      s = (act >> (2 * j)) % 4;
      r[j] = (s < nin) ? v[s] : 1'b0;
    end
    return r;
  endfunction

  task automatic tick();
    int nin;
    logic [3:0] v;
    for (int k = 0; k < 2; k++) begin
      nin = (k == 0) ? 4 : 3;
      v = (k == 0) ? in4 : {1'b0, in4[2:0]};
      if (rst) begin
        m_sh[k] = 0; m_cnt[k] = 0; m_act[k] = 0;
        m_out[k] = 2'b00; m_done[k] = 1'b0; m_err[k] = 1'b0;
      end else begin
        m_out[k] = route(m_act[k], v, nin);
        m_done[k] = 1'b0;
        m_err[k] = 1'b0;
        if (commit) begin
          if (m_cnt[k] == 4) begin
            m_act[k] = m_sh[k];
            m_done[k] = 1'b1;
          end else begin
            m_err[k] = 1'b1;
          end
          m_cnt[k] = 0;
        end else if (en) begin
          m_sh[k] = (m_sh[k] * 2 + int'(din)) % 16;
          if (m_cnt[k] < 4) m_cnt[k]++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic shift_bit(input logic b);
    en = 1'b1; din = b; commit = 1'b0;
    tick();
    en = 1'b0; din = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    tick();
    commit = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in4 = 4'b0001;
    tick(); tick();
    tests++; if (a_if.out !== 2'b00) begin fails++; $display("FAIL reset_out got=%b exp=00", a_if.out); end
    tests++; if (a_if.cfg_dout !== 1'b0) begin fails++; $display("FAIL reset_dout got=%b exp=0", a_if.cfg_dout); end
    tests++; if ({a_if.cfg_done, a_if.cfg_err} !== 2'b00) begin fails++; $display("FAIL reset_pulses got=%b exp=00", {a_if.cfg_done, a_if.cfg_err}); end
    rst = 1'b0;
    tick();
    tests++; if (a_if.out !== 2'b11) begin fails++; $display("FAIL reset_default_route got=%b exp=11", a_if.out); end
    tests++; if (b_if.out !== 2'b11) begin fails++; $display("FAIL reset_default_route_b got=%b exp=11", b_if.out); end
  endtask

  task automatic test_shift_commit();
    shift_bit(1'b1); shift_bit(1'b0); shift_bit(1'b0); shift_bit(1'b1);
    tests++; if (a_if.cfg_dout !== 1'b1) begin fails++; $display("FAIL shift_dout got=%b exp=1", a_if.cfg_dout); end
    in4 = 4'b0100;
    do_commit();
    tests++; if (a_if.cfg_done !== 1'b1 || a_if.cfg_err !== 1'b0) begin fails++; $display("FAIL commit_done got=%b%b exp=10", a_if.cfg_done, a_if.cfg_err); end
    tests++; if (a_if.out !== 2'b00) begin fails++; $display("FAIL commit_edge_old_route got=%b exp=00", a_if.out); end
    tests++; if (b_if.out !== 2'b10) begin fails++; $display("FAIL commit_comb_b got=%b exp=10", b_if.out); end
    tick();
    tests++; if (a_if.out !== 2'b10) begin fails++; $display("FAIL new_route_0100 got=%b exp=10", a_if.out); end
    tests++; if (a_if.cfg_done !== 1'b0) begin fails++; $display("FAIL done_one_cycle got=%b exp=0", a_if.cfg_done); end
    in4 = 4'b0010;
    tick();
    tests++; if (a_if.out !== 2'b01) begin fails++; $display("FAIL new_route_0010 got=%b exp=01", a_if.out); end
  endtask

  task automatic test_incomplete();
    shift_bit(1'b1); shift_bit(1'b1); shift_bit(1'b0);
    in4 = 4'b0100;
    do_commit();
    tests++; if (a_if.cfg_err !== 1'b1 || a_if.cfg_done !== 1'b0) begin fails++; $display("FAIL short_commit_err got=%b%b exp=01", a_if.cfg_done, a_if.cfg_err); end
    tick();
    tests++; if (a_if.out !== 2'b10) begin fails++; $display("FAIL err_keeps_route got=%b exp=10", a_if.out); end
    tests++; if (a_if.cfg_err !== 1'b0) begin fails++; $display("FAIL err_one_cycle got=%b exp=0", a_if.cfg_err); end
    shift_bit(1'b0); shift_bit(1'b0); shift_bit(1'b1); shift_bit(1'b1);
    in4 = 4'b1000;
    do_commit();
    tests++; if (a_if.cfg_done !== 1'b1) begin fails++; $display("FAIL recommit_done got=%b exp=1", a_if.cfg_done); end
    tick();
    tests++; if (a_if.out !== 2'b01) begin fails++; $display("FAIL recommit_route got=%b exp=01", a_if.out); end
  endtask

  task automatic test_en_with_commit();
    shift_bit(1'b0); shift_bit(1'b1); shift_bit(1'b1); shift_bit(1'b0);
    en = 1'b1; din = 1'b1; commit = 1'b1;
    tick();
    en = 1'b0; din = 1'b0; commit = 1'b0;
    tests++; if (a_if.cfg_done !== 1'b1) begin fails++; $display("FAIL en_commit_done got=%b exp=1", a_if.cfg_done); end
    tests++; if (a_if.cfg_dout !== 1'b0) begin fails++; $display("FAIL en_commit_no_shift got=%b exp=0", a_if.cfg_dout); end
    in4 = 4'b0100;
    tick(); tick();
    tests++; if (a_if.out !== 2'b01) begin fails++; $display("FAIL en_commit_route got=%b exp=01", a_if.out); end
  endtask

  task automatic test_rst_mid_shift();
    shift_bit(1'b1); shift_bit(1'b1);
    rst = 1'b1; commit = 1'b1;
    tick();
    rst = 1'b0; commit = 1'b0;
    tests++; if (a_if.out !== 2'b00) begin fails++; $display("FAIL mid_rst_out got=%b exp=00", a_if.out); end
    tests++; if ({a_if.cfg_done, a_if.cfg_err} !== 2'b00) begin fails++; $display("FAIL rst_drops_commit got=%b exp=00", {a_if.cfg_done, a_if.cfg_err}); end
    tests++; if (a_if.cfg_dout !== 1'b0) begin fails++; $display("FAIL mid_rst_dout got=%b exp=0", a_if.cfg_dout); end
    in4 = 4'b0001;
    do_commit();
    tests++; if (a_if.cfg_err !== 1'b1) begin fails++; $display("FAIL post_rst_commit_err got=%b exp=1", a_if.cfg_err); end
    tests++; if (a_if.out !== 2'b11) begin fails++; $display("FAIL post_rst_default got=%b exp=11", a_if.out); end
  endtask

  task automatic test_out_of_range();
    logic [2:0] v;
    shift_bit(1'b0); shift_bit(1'b1); shift_bit(1'b1); shift_bit(1'b1);
    do_commit();
    tests++; if (b_if.cfg_done !== 1'b1) begin fails++; $display("FAIL oor_commit_done got=%b exp=1", b_if.cfg_done); end
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      in4 = {1'b0, v};
      #1;
      tests++;
      if (b_if.out !== {v[1], 1'b0}) begin
        fails++; $display("FAIL oor_route in=%b got=%b exp=%b", v, b_if.out, {v[1], 1'b0});
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] exp_b;
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 49) == 0);
      commit = ($urandom_range(0, 6) == 0);
      en = $urandom_range(0, 1) == 1;
      din = $urandom_range(0, 1) == 1;
      in4 = 4'($urandom_range(0, 15));
      tick();
      exp_b = route(m_act[1], {1'b0, in4[2:0]}, 3);
      tests++;
      if (a_if.out !== m_out[0] || a_if.cfg_done !== m_done[0] || a_if.cfg_err !== m_err[0]
          || a_if.cfg_dout !== m_sh[0][3]) begin
        fails++;
        $display("FAIL rand_a n=%0d got out=%b d=%b e=%b q=%b exp out=%b d=%b e=%b q=%b", n,
                 a_if.out, a_if.cfg_done, a_if.cfg_err, a_if.cfg_dout,
                 m_out[0], m_done[0], m_err[0], m_sh[0][3]);
      end
      tests++;
      if (b_if.out !== exp_b || b_if.cfg_done !== m_done[1] || b_if.cfg_err !== m_err[1]
          || b_if.cfg_dout !== m_sh[1][3]) begin
        fails++;
        $display("FAIL rand_b n=%0d got out=%b d=%b e=%b q=%b exp out=%b d=%b e=%b q=%b", n,
                 b_if.out, b_if.cfg_done, b_if.cfg_err, b_if.cfg_dout,
                 exp_b, m_done[1], m_err[1], m_sh[1][3]);
      end
    end
    rst = 1'b0; commit = 1'b0; en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_shift_commit();
    test_incomplete();
    test_en_with_commit();
    test_rst_mid_shift();
    test_out_of_range();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cfg_mux_bank.md
Name: cfg_mux_bank

Overview:
- Parametrised N-input, M-output routing mux bank.
- Each output's select is held in an active configuration register.
- The active register is loaded from a serial shadow chain by an explicit commit, so routing can be reprogrammed at run time rather than fixed by a build-time MODE parameter.
- Sits between logic-box outputs and downstream routing; outputs are optionally registered.

Parameters:
- NUM_IN, 4, number of data inputs per mux (>=2).
- NUM_OUT, 2, number of independent output muxes (>=1).
- SEL_W, clog2(NUM_IN), select field width per output; derived, not overridden.
- CW, NUM_OUT*SEL_W, config chain length in bits; derived.
- REG_OUT, 1, 1 = registered outputs, 0 = combinational outputs from the active config.
- DEFAULT_SEL, 0, select value loaded into every field on reset.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in  in  NUM_IN  data inputs; bit i is mux input Ii.
- out  out  NUM_OUT  routed outputs; bit j is output j.
- cfg_en  in  1  shift one config bit this cycle.
- cfg_din  in  1  serial config data.
- cfg_dout  out  1  shadow[CW-1], for daisy-chaining banks.
- cfg_commit  in  1  request transfer of shadow to active.
- cfg_done  out  1  one-cycle pulse: commit accepted.
- cfg_err  out  1  one-cycle pulse: commit rejected (incomplete chain).

Behaviour:
- Reset (rst=1 at an edge):
  - shadow and active = DEFAULT_SEL replicated NUM_OUT times.
  - bit counter = 0.
  - out = 0, cfg_done = 0, cfg_err = 0.
- Shift: on cfg_en=1 (and cfg_commit=0):
  - shadow <= {shadow[CW-2:0], cfg_din}.
  - Counter increments and saturates at CW.
  - Extra bits keep shifting; the oldest bits fall out through cfg_dout.
- Field mapping: output j uses active[j*SEL_W +: SEL_W].
  - The first bit of a CW-bit stream lands in the MSB of output NUM_OUT-1's field.
- Commit, on cfg_commit=1, using the counter value before this edge:
  - Counter == CW: active <= shadow, counter <= 0, cfg_done=1 for the next cycle.
  - Counter != CW: active unchanged, counter <= 0, cfg_err=1 for the next cycle. shadow is retained.
  - cfg_en in the same cycle as cfg_commit is ignored; commit has priority and no shift occurs.
- Select decode: field value >= NUM_IN (non-power-of-two NUM_IN) drives that output to 0.
- REG_OUT=1:
  - out[j] <= in[active_j] every edge; latency 1 cycle from in to out.
  - A commit at edge k makes the new select active at k; out reflects it at edge k+1.
- REG_OUT=0: out[j] = in[active_j] combinationally; commit is visible right after edge k.
- Shadow state (contents and counter) is not visible on out until a successful commit.
- Reset mid-shift or mid-commit: all state returns to the reset values. A commit asserted in the same cycle as rst is dropped, with no cfg_done or cfg_err.
- No X propagation: all registers are reset and cfg_dout is defined after reset.

Decomposition:
- Shared header (included like other routing primitives) holds:
  - the clog2 function;
  - derived SEL_W/CW localparams;
  - the DEFAULT_SEL replication macro.
- Sub-module cfg_mux_sel:
  - One output: an NUM_IN:1 select with out-of-range-to-0 decode, plus the REG_OUT register.
  - Instantiated NUM_OUT times in a generate loop.
- Config chain, counter and commit logic live in the top module.

Test Plan (NUM_IN=4, NUM_OUT=2, REG_OUT=1 unless noted):
- Reset, then in=4'b0001 -> out=2'b00 at reset, then out=2'b11 one cycle later (both select I0); cfg_dout=0.
- Shift stream 1,0,0,1 (CW=4), commit, in=4'b0100 -> cfg_done pulse. Active: out1 sel=2, out0 sel=1. Next edge out=2'b10; with in=4'b0010, out=2'b01.
- Shift only 3 bits, commit -> cfg_err pulse, out keeps the previous routing. Then shift 4 more bits and commit -> cfg_done.
- cfg_en=1 and cfg_commit=1 in the same cycle with counter==CW -> commit succeeds, shadow not shifted; cfg_dout unchanged that edge.
- rst asserted between shift bits 2 and 3 -> counter 0, active=DEFAULT_SEL, out=0. A following commit gives cfg_err.
- NUM_IN=3, REG_OUT=0: commit field value 3 for out0 -> out0=0 for all in; out1 follows its select combinationally in the same cycle.
